// File: rtl/mem_range_streamer.sv
// Byte memory with a host write port and a range-streaming read engine that
// emits start..end (ascending or descending) as a valid/ready stream.
module mem_range_streamer #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] end_addr,
   input  logic          abort,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_addr,
   output logic          out_last,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   count_q, count_d;
   logic          dir_q, dir_d;

   logic [DW-1:0] mem [DEPTH];

   logic          rd_en;
   logic          rd_vld_q;
   logic [DW-1:0] rd_data_q;
   logic [AW-1:0] rd_addr_q;
   logic          rd_last_q;

   logic [DW-1:0] buf_data_q [2];
   logic [AW-1:0] buf_addr_q [2];
   logic [1:0]    buf_last_q;
   logic          wptr_q, rptr_q;
   logic [1:0]    cnt_q;

   logic          push, pop, flush, fin, done_q;
   logic [2:0]    occ;

   assign push  = rd_vld_q;
   assign pop   = out_valid && out_ready;
   assign flush = abort && (state_q != IDLE);
   // Buffer occupancy once this cycle's in-flight read lands and any pop retires;
   // a new read may only launch if its data will find a free slot.
   assign occ   = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
   assign rd_en = (state_q == STREAM) && !abort && (occ <= 3'd1);
   assign fin   = (state_q == DRAIN) && !abort && pop && (cnt_q == 2'd1) && !rd_vld_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = start_addr;
               dir_d   = start_addr > end_addr;
               count_d = dir_d ? ({1'b0, start_addr} - {1'b0, end_addr} + CNT_ONE)
                               : ({1'b0, end_addr} - {1'b0, start_addr} + CNT_ONE);
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (abort) begin
               state_d = IDLE;
            end else if (rd_en) begin
               count_d = count_q - CNT_ONE;
               if (count_q == CNT_ONE) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = dir_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
               end
            end
         end
         DRAIN: begin
            if (abort || fin) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         count_q  <= '0;
         dir_q    <= 1'b0;
         rd_vld_q <= 1'b0;
         cnt_q    <= 2'd0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         dir_q    <= dir_d;
         rd_vld_q <= rd_en;
         done_q   <= fin;
         if (flush) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            if (push) wptr_q <= ~wptr_q;
            if (pop)  rptr_q <= ~rptr_q;
         end
      end
   end

   // Storage and datapath: no reset, read-before-write on address collisions.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) begin
         rd_data_q <= mem[addr_q];
         rd_addr_q <= addr_q;
         rd_last_q <= (count_q == CNT_ONE);
      end
      if (push) begin
         buf_data_q[wptr_q] <= rd_data_q;
         buf_addr_q[wptr_q] <= rd_addr_q;
         buf_last_q[wptr_q] <= rd_last_q;
      end
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = out_valid ? buf_data_q[rptr_q] : '0;
   assign out_addr  = out_valid ? buf_addr_q[rptr_q] : '0;
   assign out_last  = out_valid ? buf_last_q[rptr_q] : 1'b0;
   assign done      = done_q;

endmodule

// File: tb/tb_mem_range_streamer.sv
// Directed bench for mem_range_streamer: ranges, backpressure, hazards,
// abort and asynchronous reset, with a byte-array reference image.
module tb_mem_range_streamer;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;
   logic       start;
   logic [9:0] start_addr;
   logic [9:0] end_addr;
   logic       abort;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [9:0] out_addr;
   logic       out_last;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] model [1024];
   bit         rp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   mem_range_streamer #(.DEPTH(1024), .AW(10), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .start_addr(start_addr), .end_addr(end_addr),
      .abort(abort), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [9:0] sa, input logic [9:0] ea, input logic ab,
                           input logic w, input logic [9:0] wa, input logic [7:0] wd);
      @(negedge clk);
      start = 1'b1; start_addr = sa; end_addr = ea; abort = ab;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (w) begin
         wr_en = 1'b1; wr_addr = wa; wr_data = wd; model[wa] = wd;
      end
      chk("start_busy", 32'(busy), 32'd1);
      chk("lat_c1", 32'(out_valid), 32'd0);
      @(negedge clk);
      wr_en = 1'b0;
      chk("lat_c2", 32'(out_valid), 32'd0);
   endtask

   task automatic collect(input logic [9:0] sa, input logic [9:0] ea, input int pat,
                          input string tag, input int wk, input logic [9:0] wa,
                          input logic [7:0] wd, input bit spur);
      int n, k, cyc, budget, isa, iea, a;
      bit stalled, pend;
      logic [18:0] held, e;
      isa = int'(sa); iea = int'(ea);
      n = (isa <= iea) ? (iea - isa + 1) : (isa - iea + 1);
      k = 0; cyc = 0; stalled = 0; pend = 0; held = '0;
      budget = 4 * n + 20;
      while (k < n && cyc < budget) begin
         @(negedge clk);
         wr_en = 1'b0; start = 1'b0;
         out_ready = (pat == 1) ? rp[cyc % 6] : 1'b1;
         if (stalled)
            chk({tag, "_hold"}, 32'({out_valid, out_last, out_addr, out_data}), 32'({1'b1, held}));
         if (pat == 0)
            chk({tag, "_nobubble"}, 32'(out_valid), 32'd1);
         if (wk >= 0 && k == wk && !pend) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd; pend = 1;
            if (spur) begin
               start = 1'b1; start_addr = 10'd700; end_addr = 10'd700;
            end
         end
         if (out_valid && out_ready) begin
            a = (isa <= iea) ? (isa + k) : (isa - k);
            e = {(k == n - 1), a[9:0], model[a[9:0]]};
            chk({tag, "_byte"}, 32'({out_last, out_addr, out_data}), 32'(e));
            k++;
            stalled = 0;
         end else if (out_valid) begin
            stalled = 1;
            held = {out_last, out_addr, out_data};
         end else begin
            stalled = 0;
         end
         cyc++;
      end
      chk({tag, "_count"}, 32'(k), 32'(n));
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      chk({tag, "_valid_off"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      out_ready = 1'b1;
      if (pend) model[wa] = wd;
   endtask

   initial begin
      int k, cyc;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; start_addr = '0; end_addr = '0; abort = 1'b0; out_ready = 1'b1;
      #23;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_vld", 32'({out_valid, out_last, out_addr, out_data, done}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = 10'(i); wr_data = 8'(i); model[i] = 8'(i);
      end
      @(negedge clk);
      wr_en = 1'b0;

      do_start(10'd10, 10'd13, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd10, 10'd13, 0, "asc4", -1, 10'd0, 8'd0, 1'b0);

      do_start(10'd200, 10'd50, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd200, 10'd50, 0, "desc", -1, 10'd0, 8'd0, 1'b0);

      do_start(10'd0, 10'd7, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd0, 10'd7, 1, "bp", -1, 10'd0, 8'd0, 1'b0);

      do_start(10'd5, 10'd5, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd5, 10'd5, 0, "single", -1, 10'd0, 8'd0, 1'b0);

      do_start(10'd0, 10'd1023, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd0, 10'd1023, 0, "full_up", -1, 10'd0, 8'd0, 1'b0);

      do_start(10'd1023, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd1023, 10'd0, 0, "full_dn", -1, 10'd0, 8'd0, 1'b0);

      // mem[20] rewritten before its read; mem[16] rewritten after its handshake,
      // together with a start that must be ignored while busy.
      do_start(10'd16, 10'd31, 1'b0, 1'b1, 10'd20, 8'hAA);
      collect(10'd16, 10'd31, 0, "hazard", 2, 10'd16, 8'h55, 1'b1);
      do_start(10'd16, 10'd20, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd16, 10'd20, 0, "reread", -1, 10'd0, 8'd0, 1'b0);

      do_start(10'd100, 10'd120, 1'b0, 1'b0, 10'd0, 8'd0);
      k = 0; cyc = 0;
      while (k < 3 && cyc < 20) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (out_valid) begin
            chk("abort_byte", 32'({out_addr, out_data}), 32'({10'(100 + k), model[10'(100 + k)]}));
            k++;
         end
         cyc++;
      end
      chk("abort_count", 32'(k), 32'd3);
      @(negedge clk);
      abort = 1'b1; out_ready = 1'b0;
      chk("abort_pre_vld", 32'(out_valid), 32'd1);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_vld", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      do_start(10'd5, 10'd5, 1'b1, 1'b0, 10'd0, 8'd0);
      collect(10'd5, 10'd5, 0, "post_abort", -1, 10'd0, 8'd0, 1'b0);

      do_start(10'd300, 10'd310, 1'b0, 1'b0, 10'd0, 8'd0);
      k = 0; cyc = 0;
      while (k < 2 && cyc < 20) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (out_valid) k++;
         cyc++;
      end
      chk("rst_mid_count", 32'(k), 32'd2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_outs", 32'({out_valid, out_last, out_addr, out_data, done}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_start(10'd300, 10'd303, 1'b0, 1'b0, 10'd0, 8'd0);
      collect(10'd300, 10'd303, 0, "rst_reread", -1, 10'd0, 8'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_range_streamer.md
Name: mem_range_streamer

Overview:
- 1024 x 8 byte memory with a host write port and a range-streaming read engine.
- On a start command, emits every byte from start_addr to end_addr inclusive as a valid/ready stream.
- Streams ascending when start_addr <= end_addr and descending when start_addr > end_addr, matching the descending-range load semantics of the memory model.
- Sits directly downstream of the memory image and feeds byte consumers, e.g. checkers and serializers.

Parameters:
- DEPTH, 1024: number of byte locations.
- AW, 10: address width; must satisfy 2**AW == DEPTH.
- DW, 8: data width in bits.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host write strobe.
- wr_addr  in  AW  host write address.
- wr_data  in  DW  host write data.
- start  in  1  one-cycle command; accepted only when busy=0.
- start_addr  in  AW  first address streamed.
- end_addr  in  AW  last address streamed.
- abort  in  1  cancels an active stream.
- busy  out  1  high from the accepted start until completion or abort.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DW  streamed byte.
- out_addr  out  AW  address of out_data.
- out_last  out  1  marks the byte at end_addr.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset values: busy=0, out_valid=0, out_data=0, out_addr=0, out_last=0, done=0; FSM in IDLE.
- Memory contents are not cleared by reset.
- Memory:
  - Synchronous write when wr_en=1.
  - Synchronous read with 1-cycle latency.
  - Same-cycle read and write to one address returns the OLD data (read-before-write).
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: start=1 latches start_addr and end_addr, computes dir (0 = up, 1 = down) and count = |end-start|+1 (range 1..1024, held in AW+1 bits), sets busy=1, goes to STREAM.
  - STREAM: issues reads, stepping the address by +1 (dir=0) or -1 (dir=1). After the read of end_addr is issued, goes to DRAIN.
  - DRAIN: waits until every fetched byte has been handshaken, then pulses done=1 for one cycle, drops busy in that same cycle, and returns to IDLE.
- start while busy=1 is ignored. It causes no error and has no side effects.
- Latency: the first out_valid rises 2 cycles after the accepted start edge.
- Throughput: with out_ready held high, one byte per clock, no bubbles, until out_last.
- Handshake:
  - A transfer occurs on a cycle where out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data, out_addr and out_last are held stable.
  - out_valid never drops without a transfer, except on abort.
- Buffering: an internal 2-entry skid/output buffer absorbs the read in flight.
  - No read is issued unless a buffer slot will be free.
  - No byte is lost or duplicated under any out_ready pattern.
- out_last=1 exactly on the byte whose out_addr equals end_addr.
- start_addr == end_addr: a single byte, with out_last=1.
- Full range, 0 to 1023 or 1023 to 0: 1024 bytes.
  - The address counter never wraps past the latched end_addr.
  - count reaches 0 without overflow.
- Writes during a stream:
  - Write to an address not yet read: the streamed byte carries the new data.
  - Write to an address already read or buffered: the streamed byte carries the old data.
- abort=1 in STREAM or DRAIN:
  - Next cycle: out_valid=0, buffer flushed, busy=0, FSM in IDLE.
  - done is not pulsed.
  - abort in IDLE has no effect.
  - abort and start in the same cycle in IDLE: start wins.
- Async reset mid-stream: all outputs immediately go to their reset values. Memory is retained.

Test Plan:
- Write mem[i]=i[7:0] for i=0..1023. start_addr=10, end_addr=13, out_ready=1 -> first valid 2 cycles after start; bytes 0x0A,0x0B,0x0C,0x0D on consecutive cycles; out_last on 0x0D; done one cycle after that transfer.
- Descending: start_addr=200, end_addr=50 -> 151 bytes, out_addr 200 down to 50, data 0xC8 down to 0x32, out_last at addr 50.
- Backpressure: range 0..7, out_ready toggling 1,0,0,1,0,1... -> exactly 8 transfers, in order, with outputs stable during every stall cycle.
- Edge ranges:
  - 5..5 -> one byte 0x05 with out_last=1.
  - 0..1023 -> 1024 bytes, last addr 1023.
  - 1023..0 -> 1024 bytes, last addr 0.
- Hazards:
  - Write mem[20]=0xAA while streaming 16..31, issued before addr 20 is read -> 0xAA streamed.
  - Write mem[16]=0x55 after 16 has been handshaken -> no change to the stream.
  - Second start while busy -> ignored.
- Abort and reset:
  - Abort after 3 transfers -> out_valid=0 and busy=0 next cycle, no done; a new start is accepted right after.
  - rst_n low mid-stream -> all outputs 0 immediately; memory contents unchanged on a re-read.
